// File: rtl/regbank_read_port.sv
// regbank_read_port: buffered register-bank read port with write bypass and a 2-entry response FIFO
module regbank_read_port #(
  parameter int n    = 16,
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int CW   = 16
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic [NREG*n-1:0] regs,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [n-1:0]    wr_data,
  input  logic            req_valid,
  input  logic [AW-1:0]   req_addr,
  output logic            req_ready,
  output logic            rsp_valid,
  output logic [n-1:0]    rsp_data,
  output logic [AW-1:0]   rsp_addr,
  output logic            rsp_err,
  input  logic            rsp_ready,
  output logic [CW-1:0]   rd_count
);
  localparam int EW = n + AW + 1;
  logic [n-1:0]  bank [2**AW];
  logic [EW-1:0] mem [2];
  logic [EW-1:0] last;
  logic [EW-1:0] entry;
  logic [1:0]    count;
  logic          wp, rp, run, err, push, pop;
  for (genvar i = 0; i < 2**AW; i++) begin : g
    if (i < NREG) begin : r
      assign bank[i] = regs[i*n +: n];
    end else begin : z
      assign bank[i] = '0;
    end
  end
  assign err       = 32'(req_addr) >= NREG;
  assign req_ready = run && count != 2'd2;
  assign rsp_valid = count != 2'd0;
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  // Snapshot the addressed register, taking the same-edge write when it targets it
  always_comb begin
    entry = {err ? '0 : (wr_en && wr_addr == req_addr) ? wr_data : bank[req_addr], req_addr, err};
  end
  assign {rsp_data, rsp_addr, rsp_err} = rsp_valid ? mem[rp] : last;
  // FIFO storage, pointers, occupancy and consumed-response counter
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      last     <= '0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      count    <= 2'd0;
      run      <= 1'b0;
      rd_count <= '0;
    end else begin
      run   <= 1'b1;
      count <= count + 2'(push) - 2'(pop);
      if (push) begin
        mem[wp] <= entry;
        wp      <= ~wp;
      end
      if (pop) begin
        last     <= mem[rp];
        rp       <= ~rp;
        rd_count <= rd_count + CW'(1);
      end
    end
  end
endmodule
